// File: rtl/load_store_unit.sv
// Load/store unit: steers RV32I byte/half/word accesses onto a single-port synchronous
// data memory, with alignment/funct3 fault detection and sign/zero extension of loads.
module load_store_unit #(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           store_data,
    output logic                  ready,
    output logic                  done,
    output logic                  fault,
    output logic [31:0]           load_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_byte_en,
    output logic [31:0]           mem_w_data,
    output logic                  mem_w_en,
    input  logic [31:0]           mem_r_data
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [2:0]  lat_funct3;
    logic [1:0]  lat_offset;
    logic [2:0]  wait_count;

    logic        accept;
    logic        misaligned;
    logic        bad_funct3;
    logic        access_fault;
    logic [3:0]  store_byte_en;
    logic [31:0] store_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] extended;

    logic        next_done;
    logic        next_fault;
    logic        next_w_en;
    logic [3:0]  next_byte_en;

    // Address bits above the memory window wrap around silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    assign ready  = (state == IDLE);
    assign accept = (state == IDLE) && req;

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        if (is_store) begin
            bad_funct3 = funct3[2] || (funct3[1:0] == 2'b11);
        end else begin
            bad_funct3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end

        access_fault = misaligned || bad_funct3;
    end

    // Narrow stores replicate the datum across all lanes; byte enables pick the lane.
    always_comb begin
        store_byte_en = 4'b1111;
        store_word    = store_data;
        case (funct3[1:0])
            2'b00: begin
                store_byte_en = 4'b0001 << addr[1:0];
                store_word    = {4{store_data[7:0]}};
            end
            2'b01: begin
                store_byte_en = addr[1] ? 4'b1100 : 4'b0011;
                store_word    = {2{store_data[15:0]}};
            end
            default: begin
                store_byte_en = 4'b1111;
                store_word    = store_data;
            end
        endcase
    end

    always_comb begin
        load_byte = mem_r_data[{lat_offset, 3'b000} +: 8];
        load_half = lat_offset[1] ? mem_r_data[31:16] : mem_r_data[15:0];
        case (lat_funct3)
            3'b000:  extended = {{24{load_byte[7]}}, load_byte};
            3'b001:  extended = {{16{load_half[15]}}, load_half};
            3'b100:  extended = {24'h000000, load_byte};
            3'b101:  extended = {16'h0000, load_half};
            default: extended = mem_r_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory strobes and done/fault are computed one state ahead so they leave registers.
    always_comb begin
        next_state   = state;
        next_done    = 1'b0;
        next_fault   = 1'b0;
        next_w_en    = 1'b0;
        next_byte_en = 4'b0000;
        case (state)
            IDLE: begin
                if (req) begin
                    if (access_fault) begin
                        next_state = DONE;
                        next_done  = 1'b1;
                        next_fault = 1'b1;
                    end else if (is_store) begin
                        next_state   = WRITE;
                        next_w_en    = 1'b1;
                        next_byte_en = store_byte_en;
                    end else begin
                        next_state   = READ_WAIT;
                        next_byte_en = 4'b1111;
                    end
                end
            end
            WRITE: begin
                next_state = DONE;
                next_done  = 1'b1;
            end
            READ_WAIT: begin
                if (wait_count == 3'd1) begin
                    next_state = DONE;
                    next_done  = 1'b1;
                end else begin
                    next_byte_en = 4'b1111;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done        <= 1'b0;
            fault       <= 1'b0;
            mem_w_en    <= 1'b0;
            mem_byte_en <= 4'b0000;
            mem_addr    <= '0;
            mem_w_data  <= 32'h0000_0000;
            load_data   <= 32'h0000_0000;
            lat_funct3  <= 3'b000;
            lat_offset  <= 2'b00;
            wait_count  <= 3'd0;
        end else begin
            done        <= next_done;
            fault       <= next_fault;
            mem_w_en    <= next_w_en;
            mem_byte_en <= next_byte_en;
            if (accept) begin
                lat_funct3 <= funct3;
                lat_offset <= addr[1:0];
                wait_count <= 3'(READ_LATENCY);
                if (!access_fault) begin
                    mem_addr <= addr[ADDR_WIDTH+1:2];
                    if (is_store) begin
                        mem_w_data <= store_word;
                    end
                end
            end else if (state == READ_WAIT) begin
                wait_count <= wait_count - 3'd1;
                if (wait_count == 3'd1) begin
                    load_data <= extended;
                end
            end
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory write/read master for the multi-cycle core.
- Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW against the single-port synchronous data memory: word address, byte enables, write data, write enable.
- Sits between the core FSM's execute/writeback states and data memory. Handshake is req/done.
- Performs byte-lane steering, sign/zero extension and alignment checks, so the core never drives memory directly.

Parameters:
- ADDR_WIDTH, 16, width of the memory word address. mem_addr = addr[ADDR_WIDTH+1:2].
- READ_LATENCY, 2, clock edges from mem_addr being driven to mem_r_data being valid. Legal values 1..4.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  asynchronous active-low reset
- req  in  1  start request; sampled only while ready=1
- is_store  in  1  1 = store, 0 = load; sampled with req
- funct3  in  3  RV32I width/sign code (inst[14:12]); sampled with req
- addr  in  32  byte address (rs1+imm); sampled with req
- store_data  in  32  rs2 value; sampled with req
- ready  out  1  unit idle, can accept req
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done: misaligned or illegal funct3
- load_data  out  32  extended load result
- mem_addr  out  ADDR_WIDTH  memory word address
- mem_byte_en  out  4  memory byteena
- mem_w_data  out  32  memory write data
- mem_w_en  out  1  memory write enable
- mem_r_data  in  32  memory read data

Behaviour:
- States: IDLE, WRITE, READ_WAIT, DONE. ready=1 only in IDLE.
- Reset (rst=0, async): state IDLE, ready=1, done=0, fault=0, load_data=0, mem_addr=0, mem_byte_en=0, mem_w_data=0, mem_w_en=0. Reset mid-operation aborts immediately; mem_w_en drops asynchronously; no partial write is completed after release.
- Accept: edge where state=IDLE and req=1. That edge latches is_store, funct3, addr and store_data. Cycle n below means n cycles after the accept edge.
- req while ready=0 is ignored. It is not queued.
- Fault check at accept; it overrides all access behaviour:
  - halfword with addr[0]=1, or word with addr[1:0]!=0, is a fault.
  - load funct3 in {011,110,111} is a fault.
  - store funct3 not in {000,001,010} is a fault.
  - On fault: next state DONE. Cycle 1: done=1, fault=1. No memory access, mem_w_en never asserts, load_data unchanged.
- Store path: IDLE -> WRITE -> DONE -> IDLE.
  - Cycle 1: mem_w_en=1, mem_addr=addr[ADDR_WIDTH+1:2].
  - SB: mem_byte_en=4'b0001<<addr[1:0]; mem_w_data = byte replicated ×4.
  - SH: mem_byte_en = 4'b0011 if addr[1]=0, else 4'b1100; mem_w_data = half replicated ×2.
  - SW: mem_byte_en=4'b1111; mem_w_data = store_data.
  - Cycle 2: done=1, fault=0.
- Load path: IDLE -> READ_WAIT -> DONE -> IDLE.
  - Cycles 1..READ_LATENCY: mem_addr driven from the latched address, mem_byte_en=4'b1111, mem_w_en=0.
  - An internal counter is loaded with READ_LATENCY on accept and decremented in READ_WAIT.
  - At the edge ending cycle READ_LATENCY, mem_r_data is sampled and load_data is registered. Lanes are little-endian: lane k = bits [8k+7:8k].
    - LB/LBU: lane addr[1:0], sign- or zero-extended.
    - LH/LHU: bits [15:0] if addr[1]=0, else [31:16], extended.
    - LW: full word.
  - Cycle READ_LATENCY+1: done=1, fault=0.
- load_data holds its value until the next successful load completes. Stores and faults do not modify it.
- Outside WRITE/READ_WAIT: mem_w_en=0, mem_byte_en=0; mem_addr and mem_w_data hold their last values.
- DONE always returns to IDLE after one cycle. Earliest next accept is the edge ending the DONE cycle + 1. Back-to-back throughput: store 3 cycles, load READ_LATENCY+2.
- Address bits above ADDR_WIDTH+1 are ignored (wrap-around). No range fault is raised.
- done and fault are registered outputs, never combinational from req.

Test Plan:
- Reset release, no req -> ready=1, done=0, mem_w_en=0 indefinitely; assert rst=0 during a store's WRITE cycle -> mem_w_en=0 same cycle, memory word unchanged, ready=1.
- SB addr=0x0000_0106, store_data=0x1234_56AB -> cycle 1: mem_addr=0x41, mem_byte_en=4'b0100, mem_w_data=0xABAB_ABAB, mem_w_en=1; cycle 2: done=1, fault=0.
- Memory word 0x41 = 0x80FF_7F01; LB addr 0x105 -> load_data=0x0000_007F; LB addr 0x107 -> 0xFFFF_FF80; LBU addr 0x107 -> 0x0000_0080; LHU addr 0x106 -> 0x0000_80FF; done exactly READ_LATENCY+1 cycles after accept.
- SW 0xDEAD_BEEF to addr 0x200, then LW addr 0x200 -> load_data=0xDEAD_BEEF, mem_byte_en=4'b1111 on the write.
- LW addr 0x202 and SH addr 0x101 -> cycle 1: done=1, fault=1; mem_w_en never asserts; load_data keeps its previous value. Load funct3=3'b011 -> fault=1.
- Hold req=1 continuously with alternating SW/LW -> exactly one accept per transaction, none while ready=0; addr 0x0004_0000 aliases word 0 (wrap).
